// File: rtl/uart_pwm_cmd_ctrl.sv
// rtl/uart_pwm_cmd_ctrl.sv - ASCII byte-command interpreter driving NUM_CH glitch-free PWM duty registers
// Define UART_PWM_READBACK_EN to add the 'R' c readback command.
module uart_pwm_cmd_ctrl #(
    parameter int NUM_CH      = 3,
    parameter int PWM_BITS    = 8,
    parameter int TIMEOUT_CYC = 1200000
) (
    input  logic              hw_clk,
    input  logic              resetn,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              busy,
    output logic [NUM_CH-1:0] pwm_out
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CH   = 3'd1;
    localparam logic [2:0] S_HI   = 3'd2;
    localparam logic [2:0] S_LO   = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;
`ifdef UART_PWM_READBACK_EN
    localparam logic [2:0] S_RCH  = 3'd5;
`endif

    // Response bytes are sent from the top of this buffer, oldest first.
    localparam logic [23:0] RESP_K   = {8'h4B, 16'h0000};
    localparam logic [23:0] RESP_ERR = {8'h3F, 16'h0000};

    logic [2:0]          state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [3:0]          hi_q, hi_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [23:0]         resp_q, resp_d;
    logic [1:0]          resp_n_q, resp_n_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [PWM_BITS-1:0] duty_q [NUM_CH];
    logic [PWM_BITS-1:0] duty_d [NUM_CH];
    logic [PWM_BITS-1:0] shadow_q [NUM_CH];
    logic [PWM_BITS-1:0] cnt_q;
    logic [NUM_CH-1:0]   pwm_q;

    logic                ch_ok;
    logic [CH_W-1:0]     ch_idx;

    function automatic logic is_hex(input logic [7:0] b);
        return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46) || (b >= 8'h61 && b <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_val(input logic [7:0] b);
        if (b <= 8'h39)
            return 4'(b - 8'h30);
        else if (b <= 8'h46)
            return 4'(b - 8'h37);
        else
            return 4'(b - 8'h57);
    endfunction

    function automatic logic is_letter(input logic [7:0] b);
        return (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
    endfunction

    assign ch_ok  = (rx_data >= 8'h30) && (rx_data < 8'(48 + NUM_CH));
    assign ch_idx = CH_W'(rx_data - 8'h30);

`ifdef UART_PWM_READBACK_EN
    logic [7:0] rb_byte;
    assign rb_byte = 8'(duty_q[ch_idx]);

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        hi_d       = hi_q;
        tmo_d      = tmo_q;
        resp_d     = resp_q;
        resp_n_d   = resp_n_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        duty_d     = duty_q;
        case (state_q)
            S_IDLE: begin
                tmo_d = '0;
                if (rx_valid) begin
                    if (rx_data == 8'h53) begin
                        state_d = S_CH;
`ifdef UART_PWM_READBACK_EN
                    end else if (rx_data == 8'h52) begin
                        state_d = S_RCH;
`endif
                    end else if (rx_data == 8'h5A) begin
                        for (int i = 0; i < NUM_CH; i++) duty_d[i] = '0;
                        state_d  = S_RESP;
                        resp_d   = RESP_K;
                        resp_n_d = 2'd1;
                    end else if (is_letter(rx_data)) begin
                        state_d  = S_RESP;
                        resp_d   = RESP_ERR;
                        resp_n_d = 2'd1;
                    end
                end
            end
            S_RESP: begin
                if (!tx_valid_q) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = resp_q[23:16];
                end else if (tx_ready) begin
                    if (resp_n_q == 2'd1) begin
                        tx_valid_d = 1'b0;
                        state_d    = S_IDLE;
                    end else begin
                        tx_data_d = resp_q[15:8];
                        resp_d    = {resp_q[15:0], 8'h00};
                        resp_n_d  = resp_n_q - 2'd1;
                    end
                end
            end
            default: begin
                // Mid-command: any byte either advances or terminates with '?'.
                if (rx_valid) begin
                    tmo_d    = '0;
                    state_d  = S_RESP;
                    resp_d   = RESP_ERR;
                    resp_n_d = 2'd1;
                    if (state_q == S_CH && ch_ok) begin
                        state_d = S_HI;
                        ch_d    = ch_idx;
                    end else if (state_q == S_HI && is_hex(rx_data)) begin
                        state_d = S_LO;
                        hi_d    = hex_val(rx_data);
                    end else if (state_q == S_LO && is_hex(rx_data)) begin
                        duty_d[ch_q] = PWM_BITS'({hi_q, hex_val(rx_data)});
                        resp_d       = RESP_K;
`ifdef UART_PWM_READBACK_EN
                    end else if (state_q == S_RCH && ch_ok) begin
                        resp_d   = {hex_char(rb_byte[7:4]), hex_char(rb_byte[3:0]), 8'h4B};
                        resp_n_d = 2'd3;
`endif
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge hw_clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            ch_q       <= '0;
            hi_q       <= '0;
            tmo_q      <= '0;
            resp_q     <= '0;
            resp_n_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            pwm_q      <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            hi_q       <= hi_d;
            tmo_q      <= tmo_d;
            resp_q     <= resp_d;
            resp_n_q   <= resp_n_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            duty_q     <= duty_d;
            cnt_q      <= cnt_q + 1'b1;
            // Shadow only changes at period end so a duty update never cuts a pulse short.
            if (cnt_q == '1) shadow_q <= duty_q;
            for (int i = 0; i < NUM_CH; i++) pwm_q[i] <= (cnt_q < shadow_q[i]);
        end
    end

    assign tx_valid = tx_valid_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != S_IDLE);
    assign pwm_out  = pwm_q;
endmodule
